// File: rtl/ysyx_22040759_id_ex.sv
`default_nettype none
// ============================================================================
//  Module   : ysyx_22040759_id_ex
//  Brief    : ID->EX pipeline register with a valid/allowin handshake, flush,
//             and load-use interlock against the held instruction.
//             The interlock is compiled in only when the macro
//             YSYX_22040759_LOAD_USE_EN is defined. Otherwise ds_stall is 0,
//             and EX must hold es_ready_go low until load data can be forwarded.
//  Revision : 1.0 - initial release
// ============================================================================
module ysyx_22040759_id_ex #(
    parameter int XLEN   = 64,
    parameter int CTRL_W = 16
) (
    input  logic              clock,
    input  logic              reset,
    // ID side
    input  logic              ds_to_es_valid,
    input  logic [XLEN-1:0]   ds_pc,
    input  logic [XLEN-1:0]   ds_rs1_data,
    input  logic [XLEN-1:0]   ds_rs2_data,
    input  logic [XLEN-1:0]   ds_imm,
    input  logic [4:0]        ds_rs1,
    input  logic [4:0]        ds_rs2,
    input  logic [4:0]        ds_rd,
    input  logic              ds_reg_wen,
    input  logic              ds_is_load,
    input  logic [CTRL_W-1:0] ds_ctrl,
    output logic              es_allowin,
    output logic              ds_stall,
    // EX / MEM handshake
    input  logic              es_ready_go,
    input  logic              ms_allowin,
    input  logic              flush,
    output logic              es_valid,
    output logic              es_to_ms_valid,
    // Registered payload
    output logic [XLEN-1:0]   es_pc,
    output logic [XLEN-1:0]   es_rs1_data,
    output logic [XLEN-1:0]   es_rs2_data,
    output logic [XLEN-1:0]   es_imm,
    output logic [4:0]        es_rs1,
    output logic [4:0]        es_rs2,
    output logic [4:0]        es_rd,
    output logic              es_reg_wen,
    output logic              es_is_load,
    output logic [CTRL_W-1:0] es_ctrl
);

    logic              r_esValid;
    logic [XLEN-1:0]   r_pc;
    logic [XLEN-1:0]   r_rs1Data;
    logic [XLEN-1:0]   r_rs2Data;
    logic [XLEN-1:0]   r_imm;
    logic [4:0]        r_rs1;
    logic [4:0]        r_rs2;
    logic [4:0]        r_rd;
    logic              r_regWen;
    logic              r_isLoad;
    logic [CTRL_W-1:0] r_ctrl;

    logic w_allowin;
    logic w_loadUse;
    logic w_stall;
    logic w_capture;

    // The stage can take a new instruction when empty or when the held one leaves.
    assign w_allowin = !r_esValid || (es_ready_go && ms_allowin);

`ifdef YSYX_22040759_LOAD_USE_EN
    // The held load's result is not yet available to the instruction in ID.
    // x0 never creates a dependency.
    assign w_loadUse = r_esValid && r_isLoad && r_regWen && (r_rd != 5'd0)
                       && ((r_rd == ds_rs1) || (r_rd == ds_rs2));
`else
    assign w_loadUse = 1'b0;
`endif

    assign w_stall   = w_loadUse && ds_to_es_valid;
    assign w_capture = w_allowin && ds_to_es_valid && !w_stall && !flush;

    // Occupancy: flush wins, then capture, then a bubble whenever the slot drains.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_esValid <= 1'b0;
        end else if (flush) begin
            r_esValid <= 1'b0;
        end else if (w_capture) begin
            r_esValid <= 1'b1;
        end else if (w_allowin) begin
            r_esValid <= 1'b0;
        end
    end

    // Payload loads only on capture; stale contents are masked by es_valid downstream.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_pc      <= '0;
            r_rs1Data <= '0;
            r_rs2Data <= '0;
            r_imm     <= '0;
            r_rs1     <= '0;
            r_rs2     <= '0;
            r_rd      <= '0;
            r_regWen  <= 1'b0;
            r_isLoad  <= 1'b0;
            r_ctrl    <= '0;
        end else if (w_capture) begin
            r_pc      <= ds_pc;
            r_rs1Data <= ds_rs1_data;
            r_rs2Data <= ds_rs2_data;
            r_imm     <= ds_imm;
            r_rs1     <= ds_rs1;
            r_rs2     <= ds_rs2;
            r_rd      <= ds_rd;
            r_regWen  <= ds_reg_wen;
            r_isLoad  <= ds_is_load;
            r_ctrl    <= ds_ctrl;
        end
    end

    assign es_allowin     = w_allowin;
    assign ds_stall       = w_stall;
    assign es_valid       = r_esValid;
    assign es_to_ms_valid = r_esValid && es_ready_go;
    assign es_pc          = r_pc;
    assign es_rs1_data    = r_rs1Data;
    assign es_rs2_data    = r_rs2Data;
    assign es_imm         = r_imm;
    assign es_rs1         = r_rs1;
    assign es_rs2         = r_rs2;
    assign es_rd          = r_rd;
    assign es_reg_wen     = r_regWen;
    assign es_is_load     = r_isLoad;
    assign es_ctrl        = r_ctrl;

endmodule
`default_nettype wire

// File: tb/tb_ysyx_22040759_id_ex.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ysyx_22040759_id_ex
//  Brief    : Directed and random stimulus against a transaction-level model
//             of the ID->EX slot (one optional held instruction).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_ysyx_22040759_id_ex;

`ifdef YSYX_22040759_LOAD_USE_EN
    localparam bit LU_EN = 1'b1;
`else
    localparam bit LU_EN = 1'b0;
`endif

    typedef struct packed {
        logic [63:0] pc;
        logic [63:0] rs1d;
        logic [63:0] rs2d;
        logic [63:0] imm;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic        wen;
        logic        ld;
        logic [15:0] ctrl;
    } insn_t;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        ds_to_es_valid = 1'b0;
    insn_t       din = '0;
    logic        es_allowin, ds_stall, es_ready_go = 1'b1, ms_allowin = 1'b1, flush = 1'b0;
    logic        es_valid, es_to_ms_valid;
    logic [63:0] es_pc, es_rs1_data, es_rs2_data, es_imm;
    logic [4:0]  es_rs1, es_rs2, es_rd;
    logic        es_reg_wen, es_is_load;
    logic [15:0] es_ctrl;

    int errors = 0;
    int checks = 0;

    // Model: the slot either holds one instruction or is empty.
    bit    mValid = 1'b0;
    insn_t mInsn  = '0;
    bit    lastStall = 1'b0;

    always #5 clock = ~clock;

    ysyx_22040759_id_ex #(.XLEN(64), .CTRL_W(16)) dut (
        .clock(clock), .reset(reset),
        .ds_to_es_valid(ds_to_es_valid),
        .ds_pc(din.pc), .ds_rs1_data(din.rs1d), .ds_rs2_data(din.rs2d), .ds_imm(din.imm),
        .ds_rs1(din.rs1), .ds_rs2(din.rs2), .ds_rd(din.rd),
        .ds_reg_wen(din.wen), .ds_is_load(din.ld), .ds_ctrl(din.ctrl),
        .es_allowin(es_allowin), .ds_stall(ds_stall),
        .es_ready_go(es_ready_go), .ms_allowin(ms_allowin), .flush(flush),
        .es_valid(es_valid), .es_to_ms_valid(es_to_ms_valid),
        .es_pc(es_pc), .es_rs1_data(es_rs1_data), .es_rs2_data(es_rs2_data), .es_imm(es_imm),
        .es_rs1(es_rs1), .es_rs2(es_rs2), .es_rd(es_rd),
        .es_reg_wen(es_reg_wen), .es_is_load(es_is_load), .es_ctrl(es_ctrl)
    );

    insn_t dutInsn;
    assign dutInsn = {es_pc, es_rs1_data, es_rs2_data, es_imm, es_rs1, es_rs2, es_rd,
                      es_reg_wen, es_is_load, es_ctrl};

    task automatic check(input string tag, input logic [319:0] obs, input logic [319:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic insn_t mk(input logic [63:0] pc, input logic [4:0] rs1, rs2, rd,
                                 input logic wen, ld);
        insn_t i;
        i.pc = pc; i.rs1d = {32'hA000_0000, pc[31:0]}; i.rs2d = ~pc; i.imm = pc ^ 64'h55;
        i.rs1 = rs1; i.rs2 = rs2; i.rd = rd; i.wen = wen; i.ld = ld; i.ctrl = pc[15:0] ^ 16'h3C;
        return i;
    endfunction

    function automatic insn_t rndInsn();
        insn_t i;
        i.pc   = {$urandom, $urandom};
        i.rs1d = {$urandom, $urandom};
        i.rs2d = {$urandom, $urandom};
        i.imm  = {$urandom, $urandom};
        i.rs1  = 5'($urandom_range(0, 7));
        i.rs2  = 5'($urandom_range(0, 7));
        i.rd   = 5'($urandom_range(0, 7));
        i.wen  = 1'($urandom_range(0, 1));
        i.ld   = 1'($urandom_range(0, 1));
        i.ctrl = 16'($urandom);
        return i;
    endfunction

    // One cycle: check combinational outputs, advance the model, check the register.
    task automatic step(input logic rg, input logic ma, input logic fl);
        bit expAllow, expHazard, expStall;
        es_ready_go = rg; ms_allowin = ma; flush = fl;
        #1;
        expAllow  = !mValid || (rg && ma);
        expHazard = LU_EN && mValid && mInsn.ld && mInsn.wen && (mInsn.rd != 0)
                    && (mInsn.rd == din.rs1 || mInsn.rd == din.rs2);
        expStall  = expHazard && ds_to_es_valid;
        check("es_allowin", 320'(es_allowin), 320'(expAllow));
        check("ds_stall", 320'(ds_stall), 320'(expStall));
        check("es_to_ms_valid", 320'(es_to_ms_valid), 320'(mValid && rg));
        lastStall = expStall;
        if (fl)
            mValid = 1'b0;
        else if (expAllow) begin
            if (ds_to_es_valid && !expStall) begin
                mValid = 1'b1;
                mInsn  = din;
            end else
                mValid = 1'b0;
        end
        @(posedge clock);
        #1;
        check("es_valid", 320'(es_valid), 320'(mValid));
        check("payload", 320'(dutInsn), 320'(mInsn));
    endtask

    initial begin
        // Reset state
        #1 reset = 1'b1;
        #1;
        check("reset_valid", 320'(es_valid), 320'(0));
        check("reset_payload", 320'(dutInsn), 320'(0));
        check("reset_allowin", 320'(es_allowin), 320'(1));
        check("reset_stall", 320'(ds_stall), 320'(0));
        check("reset_to_ms", 320'(es_to_ms_valid), 320'(0));
        @(posedge clock);
        @(posedge clock);
        #1 reset = 1'b0;

        // First capture
        ds_to_es_valid = 1'b1;
        din = mk(64'h8000_0000, 5'd1, 5'd2, 5'd3, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        check("first_pc", 320'(es_pc), 320'(64'h8000_0000));
        ds_to_es_valid = 1'b0;
        step(1'b0, 1'b1, 1'b0);

        // Back-to-back independent stream
        for (int k = 0; k < 4; k++) begin
            ds_to_es_valid = 1'b1;
            din = mk(64'h8000_0100 + 64'(4 * k), 5'(k + 10), 5'(k + 20), 5'(k + 1), 1'b1, 1'b0);
            step(1'b1, 1'b1, 1'b0);
            check("stream_pc", 320'(es_pc), 320'(64'h8000_0100 + 64'(4 * k)));
        end

        // Load-use: ld x5, then add x6, x5, x1
        din = mk(64'h8000_0200, 5'd2, 5'd0, 5'd5, 1'b1, 1'b1);
        step(1'b1, 1'b1, 1'b0);
        din = mk(64'h8000_0204, 5'd5, 5'd1, 5'd6, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        check("lu_bubble", 320'(es_valid), 320'(!LU_EN));
        if (LU_EN) step(1'b1, 1'b1, 1'b0);
        check("lu_add_rs1", 320'(es_rs1), 320'(5));
        check("lu_add_pc", 320'(es_pc), 320'(64'h8000_0204));

        // Same with rd = x0: no interlock
        din = mk(64'h8000_0300, 5'd0, 5'd0, 5'd0, 1'b1, 1'b1);
        step(1'b1, 1'b1, 1'b0);
        din = mk(64'h8000_0304, 5'd0, 5'd1, 5'd6, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        check("x0_no_bubble", 320'(es_valid), 320'(1));

        // Backpressure from MEM for 3 cycles
        din = mk(64'h8000_0400, 5'd7, 5'd8, 5'd9, 1'b1, 1'b0);
        for (int k = 0; k < 3; k++) begin
            step(1'b1, 1'b0, 1'b0);
            check("bp_hold_pc", 320'(es_pc), 320'(64'h8000_0304));
        end
        step(1'b1, 1'b1, 1'b0);
        check("bp_advance_pc", 320'(es_pc), 320'(64'h8000_0400));

        // Flush with an incoming instruction
        din = mk(64'h8000_0500, 5'd1, 5'd1, 5'd1, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b1);
        check("flush_valid", 320'(es_valid), 320'(0));
        check("flush_no_capture", 320'(es_pc), 320'(64'h8000_0400));

        // Refill, then asynchronous reset pulse between edges
        step(1'b1, 1'b1, 1'b0);
        #2 reset = 1'b1;
        #1;
        check("async_reset_valid", 320'(es_valid), 320'(0));
        check("async_reset_payload", 320'(dutInsn), 320'(0));
        #1 reset = 1'b0;
        mValid = 1'b0;
        mInsn  = '0;
        step(1'b1, 1'b1, 1'b0);
        check("post_reset_capture", 320'(es_pc), 320'(64'h8000_0500));

        // Random traffic; ID holds its instruction while stalled
        for (int n = 0; n < 300; n++) begin
            if (!lastStall) begin
                ds_to_es_valid = ($urandom_range(0, 3) != 0);
                din = rndInsn();
            end
            step(($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0),
                 ($urandom_range(0, 15) == 0));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
